id_exe_stage_reg: RTL and testbench

- Pipeline register between the ID stage and the EXE stage of the ARM968E-S core.
- Captures the decoded control, operand and forwarding fields that ID produces each cycle and presents them to EXE one cycle later.
- Supports freeze (hold) and flush (bubble insertion on a taken branch).
- Keeps saturating bubble and stall counters for pipeline debug.

---
 rtl/arm_pipe_pkg.sv | 47 ++++
 rtl/sat_counter.sv | 25 ++
 rtl/id_exe_stage_reg.sv | 123 ++++++++++++
 tb/tb_id_exe_stage_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM968E-S pipeline slice.
// Holds the ALU command encodings and the ID/EXE register bundle.
package arm_pipe_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int WORD_W     = 32;
    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;
    localparam int SR_W       = 4;
    localparam int CMD_W      = 4;

    localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] EXE_CMP = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_TST = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_LDR = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_STR = 4'b0010;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  b;
        logic                  s;
        logic [CMD_W-1:0]      exe_cmd;
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     val_rn;
        logic [WORD_W-1:0]     val_rm;
        logic                  imm;
        logic [SHIFT_OP_W-1:0] shift_op;
        logic [IMM24_W-1:0]    simm24;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic [SR_W-1:0]       sr;
    } id_exe_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with flush, freeze and debug counters.
// Bubbles carry data but never carry live control bits.
module id_exe_stage_reg
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  clr_cnt,
    input  logic                  valid_in,
    input  logic                  WB_EN_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic                  B_in,
    input  logic                  S_in,
    input  logic [CMD_W-1:0]      EXE_CMD_in,
    input  logic [WORD_W-1:0]     PC_in,
    input  logic [WORD_W-1:0]     Val_Rn_in,
    input  logic [WORD_W-1:0]     Val_Rm_in,
    input  logic                  imm_in,
    input  logic [SHIFT_OP_W-1:0] Shift_operand_in,
    input  logic [IMM24_W-1:0]    Signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0] Dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic [SR_W-1:0]       SR_in,
    output logic                  valid_out,
    output logic                  WB_EN_out,
    output logic                  MEM_R_EN_out,
    output logic                  MEM_W_EN_out,
    output logic                  B_out,
    output logic                  S_out,
    output logic [CMD_W-1:0]      EXE_CMD_out,
    output logic [WORD_W-1:0]     PC_out,
    output logic [WORD_W-1:0]     Val_Rn_out,
    output logic [WORD_W-1:0]     Val_Rm_out,
    output logic                  imm_out,
    output logic [SHIFT_OP_W-1:0] Shift_operand_out,
    output logic [IMM24_W-1:0]    Signed_imm_24_out,
    output logic [REG_ADDR_W-1:0] Dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic [SR_W-1:0]       SR_out,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    id_exe_t r_q;
    id_exe_t w_ld;
    logic    w_bubble_inc;
    logic    w_stall_inc;

    always_comb begin
        w_ld          = '0;
        w_ld.valid    = valid_in;
        w_ld.wb_en    = valid_in & WB_EN_in;
        w_ld.mem_r_en = valid_in & MEM_R_EN_in;
        w_ld.mem_w_en = valid_in & MEM_W_EN_in;
        w_ld.b        = valid_in & B_in;
        w_ld.s        = valid_in & S_in;
        w_ld.exe_cmd  = EXE_CMD_in;
        w_ld.pc       = PC_in;
        w_ld.val_rn   = Val_Rn_in;
        w_ld.val_rm   = Val_Rm_in;
        w_ld.imm      = imm_in;
        w_ld.shift_op = Shift_operand_in;
        w_ld.simm24   = Signed_imm_24_in;
        w_ld.dest     = Dest_in;
        w_ld.src1     = src1_in;
        w_ld.src2     = src2_in;
        w_ld.sr       = SR_in;
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_q <= '0;
        end else if (!freeze) begin
            r_q <= w_ld;
        end
    end

    // A frozen hazard slot is a stall, not a new bubble.
    assign w_bubble_inc = flush | (~freeze & ~valid_in);
    assign w_stall_inc  = freeze & ~flush;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_bubble_inc),
        .cnt (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_stall_inc),
        .cnt (stall_cnt)
    );

    assign valid_out         = r_q.valid;
    assign WB_EN_out         = r_q.wb_en;
    assign MEM_R_EN_out      = r_q.mem_r_en;
    assign MEM_W_EN_out      = r_q.mem_w_en;
    assign B_out             = r_q.b;
    assign S_out             = r_q.s;
    assign EXE_CMD_out       = r_q.exe_cmd;
    assign PC_out            = r_q.pc;
    assign Val_Rn_out        = r_q.val_rn;
    assign Val_Rm_out        = r_q.val_rm;
    assign imm_out           = r_q.imm;
    assign Shift_operand_out = r_q.shift_op;
    assign Signed_imm_24_out = r_q.simm24;
    assign Dest_out          = r_q.dest;
    assign src1_out          = r_q.src1;
    assign src2_out          = r_q.src2;
    assign SR_out            = r_q.sr;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg with hand-computed vectors.
// Counters are 2 bits wide so saturation is reached quickly.
module tb_id_exe_stage_reg;
    import arm_pipe_pkg::*;

    localparam int CW = 2;

    typedef struct packed {
        id_exe_t       f;
        logic [CW-1:0] bc;
        logic [CW-1:0] sc;
    } obs_t;

    logic    clk = 1'b0;
    logic    rst, flush, freeze, clr_cnt;
    id_exe_t drv;

    logic                  valid_out, WB_EN_out, MEM_R_EN_out;
    logic                  MEM_W_EN_out, B_out, S_out, imm_out;
    logic [CMD_W-1:0]      EXE_CMD_out;
    logic [WORD_W-1:0]     PC_out, Val_Rn_out, Val_Rm_out;
    logic [SHIFT_OP_W-1:0] Shift_operand_out;
    logic [IMM24_W-1:0]    Signed_imm_24_out;
    logic [REG_ADDR_W-1:0] Dest_out, src1_out, src2_out;
    logic [SR_W-1:0]       SR_out;
    logic [CW-1:0]         bubble_cnt, stall_cnt;

    obs_t  got;
    obs_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .freeze            (freeze),
        .clr_cnt           (clr_cnt),
        .valid_in          (drv.valid),
        .WB_EN_in          (drv.wb_en),
        .MEM_R_EN_in       (drv.mem_r_en),
        .MEM_W_EN_in       (drv.mem_w_en),
        .B_in              (drv.b),
        .S_in              (drv.s),
        .EXE_CMD_in        (drv.exe_cmd),
        .PC_in             (drv.pc),
        .Val_Rn_in         (drv.val_rn),
        .Val_Rm_in         (drv.val_rm),
        .imm_in            (drv.imm),
        .Shift_operand_in  (drv.shift_op),
        .Signed_imm_24_in  (drv.simm24),
        .Dest_in           (drv.dest),
        .src1_in           (drv.src1),
        .src2_in           (drv.src2),
        .SR_in             (drv.sr),
        .valid_out         (valid_out),
        .WB_EN_out         (WB_EN_out),
        .MEM_R_EN_out      (MEM_R_EN_out),
        .MEM_W_EN_out      (MEM_W_EN_out),
        .B_out             (B_out),
        .S_out             (S_out),
        .EXE_CMD_out       (EXE_CMD_out),
        .PC_out            (PC_out),
        .Val_Rn_out        (Val_Rn_out),
        .Val_Rm_out        (Val_Rm_out),
        .imm_out           (imm_out),
        .Shift_operand_out (Shift_operand_out),
        .Signed_imm_24_out (Signed_imm_24_out),
        .Dest_out          (Dest_out),
        .src1_out          (src1_out),
        .src2_out          (src2_out),
        .SR_out            (SR_out),
        .bubble_cnt        (bubble_cnt),
        .stall_cnt         (stall_cnt)
    );

    assign got = {valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out,
                  B_out, S_out, EXE_CMD_out, PC_out, Val_Rn_out,
                  Val_Rm_out, imm_out, Shift_operand_out,
                  Signed_imm_24_out, Dest_out, src1_out, src2_out,
                  SR_out, bubble_cnt, stall_cnt};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got=%h exp=%h", n, got, e);
            end
        end
    end

    function automatic id_exe_t mk(
        input logic v, wb, mr, mw, b, s,
        input logic [3:0] cmd,
        input logic [31:0] pc, rn, rm,
        input logic im,
        input logic [11:0] sh,
        input logic [23:0] o24,
        input logic [3:0] d, s1, s2, sr
    );
        id_exe_t r;
        r = {v, wb, mr, mw, b, s, cmd, pc, rn, rm, im, sh, o24,
             d, s1, s2, sr};
        return r;
    endfunction

    task automatic step(
        input id_exe_t d,
        input logic fl, fz, cl, r,
        input id_exe_t ef,
        input logic [CW-1:0] ebc, esc,
        input string nm
    );
        obs_t e;
        drv     = d;
        flush   = fl;
        freeze  = fz;
        clr_cnt = cl;
        rst     = r;
        @(posedge clk);
        e.f  = ef;
        e.bc = ebc;
        e.sc = esc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    id_exe_t Z, ONES, A, F, BV, H, HX, C, D;

    initial begin
        Z    = '0;
        ONES = '1;
        A  = mk(1, 1, 0, 0, 0, 0, 4'b0010, 32'h0000_0008,
                32'h1234_5678, 32'h0, 0, 12'h0, 24'h0,
                4'h3, 4'h0, 4'h0, 4'h0);
        F  = mk(1, 0, 1, 1, 1, 1, 4'hF, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 12'hFFF,
                24'hFF_FFFF, 4'hF, 4'hF, 4'hF, 4'hF);
        BV = mk(1, 1, 1, 0, 1, 0, 4'b0100, 32'h0000_0020,
                32'h1, 32'h2, 1, 12'h123, 24'h00_ABCD,
                4'h5, 4'h6, 4'h7, 4'b1010);
        H  = mk(0, 1, 0, 1, 1, 0, 4'b0110, 32'h0000_0010,
                32'h55, 32'hA5A5_A5A5, 0, 12'h0F0, 24'h00_0010,
                4'h9, 4'h1, 4'h2, 4'h4);
        HX = mk(0, 0, 0, 0, 0, 0, 4'b0110, 32'h0000_0010,
                32'h55, 32'hA5A5_A5A5, 0, 12'h0F0, 24'h00_0010,
                4'h9, 4'h1, 4'h2, 4'h4);
        C  = mk(1, 1, 1, 1, 1, 1, 4'b1001, 32'h1000_0004,
                32'hCAFE_F00D, 32'h0BAD_BEEF, 1, 12'hA5A,
                24'h80_0001, 4'hE, 4'hD, 4'hC, 4'b0110);
        D  = mk(1, 0, 0, 1, 0, 1, 4'b0111, 32'h0000_0044,
                32'h3, 32'h4, 0, 12'h001, 24'hFF_FFFE,
                4'h2, 4'h8, 4'hB, 4'h1);

        for (int i = 0; i < 3; i++)
            step(ONES, 1, 1, 1, 0, Z, 2'd0, 2'd0, "reset");
        step(A, 0, 0, 0, 1, A, 2'd0, 2'd0, "load");
        step(F, 0, 1, 0, 1, A, 2'd0, 2'd1, "freeze1");
        step(F, 0, 1, 0, 1, A, 2'd0, 2'd2, "freeze2");
        step(F, 0, 1, 0, 1, A, 2'd0, 2'd3, "freeze3");
        step(BV, 1, 1, 0, 1, Z, 2'd1, 2'd3, "flush_frz");
        step(H, 0, 0, 0, 1, HX, 2'd2, 2'd3, "hazard");
        step(C, 0, 0, 1, 1, C, 2'd0, 2'd0, "clr_load");
        step(BV, 1, 0, 0, 1, Z, 2'd1, 2'd0, "flush_sat1");
        step(BV, 1, 0, 0, 1, Z, 2'd2, 2'd0, "flush_sat2");
        step(BV, 1, 0, 0, 1, Z, 2'd3, 2'd0, "flush_sat3");
        step(BV, 1, 0, 0, 1, Z, 2'd3, 2'd0, "flush_sat4");
        step(BV, 1, 0, 0, 1, Z, 2'd3, 2'd0, "flush_sat5");
        step(BV, 1, 0, 1, 1, Z, 2'd0, 2'd0, "clr_flush");
        step(D, 0, 0, 0, 1, D, 2'd0, 2'd0, "load_d");
        step(H, 0, 1, 0, 1, D, 2'd0, 2'd1, "freeze_v0");
        step(C, 0, 1, 0, 0, Z, 2'd0, 2'd0, "rst_frz");
        step(C, 0, 0, 0, 1, C, 2'd0, 2'd0, "post_rst");
        step(F, 0, 1, 0, 1, C, 2'd0, 2'd1, "stall_sat1");
        step(F, 0, 1, 0, 1, C, 2'd0, 2'd2, "stall_sat2");
        step(F, 0, 1, 0, 1, C, 2'd0, 2'd3, "stall_sat3");
        step(F, 0, 1, 0, 1, C, 2'd0, 2'd3, "stall_sat4");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
